execute_cycle: RTL and testbench



---
 rtl/pipeline_pkg.sv | 19 +
 rtl/alu.sv | 28 ++
 rtl/execute_cycle.sv | 93 +++++++++
 tb/tb_execute_cycle.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the RV32I pipeline: data width, ALU op codes
// and hazard-unit forwarding selects.
package pipeline_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU; code 111 and anything unlisted produce zero.
module alu
    import pipeline_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      ALUControl,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    always_comb begin
        result = '0;
        case (ALUControl)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, beq decision/target and the
// EX/MEM pipeline register.
module execute_cycle
    import pipeline_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            ALUSrcE,
    input  logic            MemWriteE,
    input  logic            ResultSrcE,
    input  logic            BranchE,
    input  logic [2:0]      ALUControlE,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] Imm_Ext_E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [4:0]      RD_E,
    input  logic [1:0]      ForwardA_E,
    input  logic [1:0]      ForwardB_E,
    input  logic [XLEN-1:0] ResultW,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic            ResultSrcM,
    output logic [4:0]      RD_M,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M
);

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b_fwd;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;

    // Select 11 is unused by the hazard unit and falls back to the register value.
    always_comb begin
        src_a = RD1_E;
        case (ForwardA_E)
            FWD_WB:  src_a = ResultW;
            FWD_MEM: src_a = ALUResultM;
            default: src_a = RD1_E;
        endcase
    end

    always_comb begin
        src_b_fwd = RD2_E;
        case (ForwardB_E)
            FWD_WB:  src_b_fwd = ResultW;
            FWD_MEM: src_b_fwd = ALUResultM;
            default: src_b_fwd = RD2_E;
        endcase
    end

    assign src_b = ALUSrcE ? Imm_Ext_E : src_b_fwd;

    alu u_alu (
        .a          (src_a),
        .b          (src_b),
        .ALUControl (ALUControlE),
        .result     (alu_result),
        .zero       (alu_zero)
    );

    assign PCSrcE    = BranchE & alu_zero;
    assign PCTargetE = PCE + Imm_Ext_E;

    // Store data is the forwarded rs2 value, never the immediate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 1'b0;
            RD_M       <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
        end else begin
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            RD_M       <= RD_E;
            ALUResultM <= alu_result;
            WriteDataM <= src_b_fwd;
            PCPlus4M   <= PCPlus4E;
        end
    end

endmodule

// File: tb/tb_execute_cycle.sv
// Directed self-checking bench for execute_cycle with hand-computed expectations.
module tb_execute_cycle;

    logic        clk;
    logic        rst;
    logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

    int n_checks;
    int n_fail;

    execute_cycle dut (
        .clk         (clk),
        .rst         (rst),
        .RegWriteE   (RegWriteE),
        .ALUSrcE     (ALUSrcE),
        .MemWriteE   (MemWriteE),
        .ResultSrcE  (ResultSrcE),
        .BranchE     (BranchE),
        .ALUControlE (ALUControlE),
        .RD1_E       (RD1_E),
        .RD2_E       (RD2_E),
        .Imm_Ext_E   (Imm_Ext_E),
        .PCE         (PCE),
        .PCPlus4E    (PCPlus4E),
        .RD_E        (RD_E),
        .ForwardA_E  (ForwardA_E),
        .ForwardB_E  (ForwardB_E),
        .ResultW     (ResultW),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .RegWriteM   (RegWriteM),
        .MemWriteM   (MemWriteM),
        .ResultSrcM  (ResultSrcM),
        .RD_M        (RD_M),
        .ALUResultM  (ALUResultM),
        .WriteDataM  (WriteDataM),
        .PCPlus4M    (PCPlus4M)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; ResultSrcE = 0; BranchE = 0;
        ALUControlE = 3'b000;
        RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0; ResultW = 0;
        RD_E = 0; ForwardA_E = 2'b00; ForwardB_E = 2'b00;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_checks++; if (RegWriteM !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite: got %b expected 0", RegWriteM); end
        n_checks++; if (MemWriteM !== 1'b0) begin n_fail++; $display("FAIL reset_memwrite: got %b expected 0", MemWriteM); end
        n_checks++; if (ResultSrcM !== 1'b0) begin n_fail++; $display("FAIL reset_resultsrc: got %b expected 0", ResultSrcM); end
        n_checks++; if (RD_M !== 5'd0) begin n_fail++; $display("FAIL reset_rd: got %0d expected 0", RD_M); end
        n_checks++; if (ALUResultM !== 32'h0) begin n_fail++; $display("FAIL reset_aluresult: got %h expected 0", ALUResultM); end
        n_checks++; if (WriteDataM !== 32'h0) begin n_fail++; $display("FAIL reset_writedata: got %h expected 0", WriteDataM); end
        n_checks++; if (PCPlus4M !== 32'h0) begin n_fail++; $display("FAIL reset_pcplus4: got %h expected 0", PCPlus4M); end
    endtask

    task automatic test_add_imm();
        clear_inputs();
        RD1_E = 5; Imm_Ext_E = 7; ALUSrcE = 1; ALUControlE = 3'b000; RegWriteE = 1; RD_E = 3;
        RD2_E = 32'h99; PCPlus4E = 32'h24;
        step();
        n_checks++; if (ALUResultM !== 32'd12) begin n_fail++; $display("FAIL addi_result: got %h expected 0000000c", ALUResultM); end
        n_checks++; if (RD_M !== 5'd3) begin n_fail++; $display("FAIL addi_rd: got %0d expected 3", RD_M); end
        n_checks++; if (RegWriteM !== 1'b1) begin n_fail++; $display("FAIL addi_regwrite: got %b expected 1", RegWriteM); end
        n_checks++; if (PCPlus4M !== 32'h24) begin n_fail++; $display("FAIL addi_pcplus4: got %h expected 00000024", PCPlus4M); end
        n_checks++; if (WriteDataM !== 32'h99) begin n_fail++; $display("FAIL addi_writedata: got %h expected 00000099", WriteDataM); end
    endtask

    task automatic test_branch();
        clear_inputs();
        RD1_E = 32'h10; RD2_E = 32'h10; ALUControlE = 3'b001; BranchE = 1;
        PCE = 32'h100; Imm_Ext_E = 32'h20;
        #1;
        n_checks++; if (PCSrcE !== 1'b1) begin n_fail++; $display("FAIL beq_taken: got %b expected 1", PCSrcE); end
        n_checks++; if (PCTargetE !== 32'h120) begin n_fail++; $display("FAIL beq_target: got %h expected 00000120", PCTargetE); end
        RD2_E = 32'h11;
        #1;
        n_checks++; if (PCSrcE !== 1'b0) begin n_fail++; $display("FAIL beq_not_taken: got %b expected 0", PCSrcE); end
        n_checks++; if (PCTargetE !== 32'h120) begin n_fail++; $display("FAIL beq_target_nt: got %h expected 00000120", PCTargetE); end
        // Zero result without BranchE must not redirect.
        RD2_E = 32'h10; BranchE = 0;
        #1;
        n_checks++; if (PCSrcE !== 1'b0) begin n_fail++; $display("FAIL beq_no_branch: got %b expected 0", PCSrcE); end
        PCE = 32'hFFFF_FFF0; Imm_Ext_E = 32'h20;
        #1;
        n_checks++; if (PCTargetE !== 32'h10) begin n_fail++; $display("FAIL target_wrap: got %h expected 00000010", PCTargetE); end
        step();
    endtask

    task automatic test_forwarding();
        clear_inputs();
        RD1_E = 32'h40; ALUControlE = 3'b000;
        step();
        RD1_E = 0; RD2_E = 2; ForwardA_E = 2'b10;
        step();
        n_checks++; if (ALUResultM !== 32'h42) begin n_fail++; $display("FAIL fwd_mem_a: got %h expected 00000042", ALUResultM); end
        RD1_E = 0; RD2_E = 5; ForwardA_E = 2'b00; ForwardB_E = 2'b01; ResultW = 9;
        step();
        n_checks++; if (WriteDataM !== 32'h9) begin n_fail++; $display("FAIL fwd_wb_b_store: got %h expected 00000009", WriteDataM); end
        n_checks++; if (ALUResultM !== 32'h9) begin n_fail++; $display("FAIL fwd_wb_b_alu: got %h expected 00000009", ALUResultM); end
        RD1_E = 3; RD2_E = 4; ForwardA_E = 2'b11; ForwardB_E = 2'b00; ResultW = 100;
        step();
        n_checks++; if (ALUResultM !== 32'h7) begin n_fail++; $display("FAIL fwd_sel11: got %h expected 00000007", ALUResultM); end
        RD1_E = 1; RD2_E = 32'hDEAD; ForwardA_E = 2'b01; ResultW = 32'h20;
        ForwardB_E = 2'b10; ALUSrcE = 1; Imm_Ext_E = 32'h10;
        step();
        n_checks++; if (ALUResultM !== 32'h30) begin n_fail++; $display("FAIL imm_over_fwd_alu: got %h expected 00000030", ALUResultM); end
        n_checks++; if (WriteDataM !== 32'h7) begin n_fail++; $display("FAIL imm_over_fwd_store: got %h expected 00000007", WriteDataM); end
    endtask

    task automatic test_compare_wrap();
        clear_inputs();
        RD1_E = 32'hFFFF_FFFF; RD2_E = 1; ALUControlE = 3'b101;
        step();
        n_checks++; if (ALUResultM !== 32'h1) begin n_fail++; $display("FAIL slt_neg: got %h expected 00000001", ALUResultM); end
        ALUControlE = 3'b110;
        step();
        n_checks++; if (ALUResultM !== 32'h0) begin n_fail++; $display("FAIL sltu_big: got %h expected 00000000", ALUResultM); end
        ALUControlE = 3'b000;
        step();
        n_checks++; if (ALUResultM !== 32'h0) begin n_fail++; $display("FAIL add_wrap: got %h expected 00000000", ALUResultM); end
        RD1_E = 0; ALUControlE = 3'b001;
        step();
        n_checks++; if (ALUResultM !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sub_wrap: got %h expected ffffffff", ALUResultM); end
        RD1_E = 32'hF0F0_1234; RD2_E = 32'h0FF0_00FF; ALUControlE = 3'b010;
        step();
        n_checks++; if (ALUResultM !== 32'h00F0_0034) begin n_fail++; $display("FAIL and_op: got %h expected 00f00034", ALUResultM); end
        ALUControlE = 3'b011;
        step();
        n_checks++; if (ALUResultM !== 32'hFFF0_12FF) begin n_fail++; $display("FAIL or_op: got %h expected fff012ff", ALUResultM); end
        ALUControlE = 3'b100;
        step();
        n_checks++; if (ALUResultM !== 32'hFF00_12CB) begin n_fail++; $display("FAIL xor_op: got %h expected ff0012cb", ALUResultM); end
        ALUControlE = 3'b111;
        step();
        n_checks++; if (ALUResultM !== 32'h0) begin n_fail++; $display("FAIL op111_zero: got %h expected 00000000", ALUResultM); end
        RD1_E = 2; RD2_E = 32'hFFFF_FFFE; ALUControlE = 3'b101;
        step();
        n_checks++; if (ALUResultM !== 32'h0) begin n_fail++; $display("FAIL slt_pos_vs_neg: got %h expected 00000000", ALUResultM); end
        ALUControlE = 3'b110;
        step();
        n_checks++; if (ALUResultM !== 32'h1) begin n_fail++; $display("FAIL sltu_small: got %h expected 00000001", ALUResultM); end
    endtask

    task automatic test_store();
        clear_inputs();
        ALUSrcE = 1; Imm_Ext_E = 8; RD1_E = 32'h1000; RD2_E = 32'hAB; MemWriteE = 1;
        ResultSrcE = 1; RD_E = 5'd17;
        step();
        n_checks++; if (ALUResultM !== 32'h1008) begin n_fail++; $display("FAIL store_addr: got %h expected 00001008", ALUResultM); end
        n_checks++; if (WriteDataM !== 32'hAB) begin n_fail++; $display("FAIL store_data: got %h expected 000000ab", WriteDataM); end
        n_checks++; if (MemWriteM !== 1'b1) begin n_fail++; $display("FAIL store_memwrite: got %b expected 1", MemWriteM); end
        n_checks++; if (ResultSrcM !== 1'b1) begin n_fail++; $display("FAIL store_resultsrc: got %b expected 1", ResultSrcM); end
        n_checks++; if (RD_M !== 5'd17) begin n_fail++; $display("FAIL store_rd: got %0d expected 17", RD_M); end
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        RegWriteE = 1; MemWriteE = 1; ResultSrcE = 1; RD_E = 5'd9;
        RD1_E = 32'h55; RD2_E = 32'h66; PCPlus4E = 32'h808; ALUControlE = 3'b000;
        step();
        n_checks++; if (ALUResultM !== 32'hBB) begin n_fail++; $display("FAIL pre_reset_load: got %h expected 000000bb", ALUResultM); end
        #2;
        rst = 1;
        #1;
        n_checks++; if (ALUResultM !== 32'h0) begin n_fail++; $display("FAIL async_rst_alu: got %h expected 0", ALUResultM); end
        n_checks++; if (WriteDataM !== 32'h0) begin n_fail++; $display("FAIL async_rst_wdata: got %h expected 0", WriteDataM); end
        n_checks++; if (PCPlus4M !== 32'h0) begin n_fail++; $display("FAIL async_rst_pc4: got %h expected 0", PCPlus4M); end
        n_checks++; if ({RegWriteM, MemWriteM, ResultSrcM} !== 3'b000) begin n_fail++; $display("FAIL async_rst_ctrl: got %b expected 000", {RegWriteM, MemWriteM, ResultSrcM}); end
        n_checks++; if (RD_M !== 5'd0) begin n_fail++; $display("FAIL async_rst_rd: got %0d expected 0", RD_M); end
        step();
        n_checks++; if (ALUResultM !== 32'h0) begin n_fail++; $display("FAIL held_rst_alu: got %h expected 0", ALUResultM); end
        n_checks++; if (RegWriteM !== 1'b0) begin n_fail++; $display("FAIL held_rst_regwrite: got %b expected 0", RegWriteM); end
        // Combinational branch outputs are independent of reset.
        PCE = 32'h200; Imm_Ext_E = 32'h4; BranchE = 1; RD2_E = 32'h55; ALUControlE = 3'b001;
        #1;
        n_checks++; if (PCTargetE !== 32'h204) begin n_fail++; $display("FAIL rst_target: got %h expected 00000204", PCTargetE); end
        n_checks++; if (PCSrcE !== 1'b1) begin n_fail++; $display("FAIL rst_pcsrc: got %b expected 1", PCSrcE); end
        @(negedge clk);
        rst = 0;
        RD1_E = 32'h30; RD2_E = 32'h12; ALUControlE = 3'b001; RD_E = 5'd4; PCPlus4E = 32'h40C;
        step();
        n_checks++; if (ALUResultM !== 32'h1E) begin n_fail++; $display("FAIL post_rst_alu: got %h expected 0000001e", ALUResultM); end
        n_checks++; if (RD_M !== 5'd4) begin n_fail++; $display("FAIL post_rst_rd: got %0d expected 4", RD_M); end
        n_checks++; if (PCPlus4M !== 32'h40C) begin n_fail++; $display("FAIL post_rst_pc4: got %h expected 0000040c", PCPlus4M); end
        n_checks++; if (RegWriteM !== 1'b1) begin n_fail++; $display("FAIL post_rst_regwrite: got %b expected 1", RegWriteM); end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst = 1;
        clear_inputs();
        #2;
        test_reset();
        @(negedge clk);
        rst = 0;
        test_add_imm();
        test_branch();
        test_forwarding();
        test_compare_wrap();
        test_store();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
